// File: rtl/stump_ctrl_pkg.sv
// stump_ctrl_pkg: shared state encoding, opcodes, condition codes and instruction field positions for the Stump control unit
package stump_ctrl_pkg;
  localparam logic [2:0] S_INIT = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_HALT = 3'd4;
  localparam logic [2:0] OP_ADD = 3'd0, OP_ADC = 3'd1, OP_SUB = 3'd2, OP_SBC = 3'd3,
                         OP_AND = 3'd4, OP_OR = 3'd5, OP_MEM = 3'd6, OP_BCC = 3'd7;
  localparam logic [3:0] CC_AL = 4'h0, CC_NV = 4'h1, CC_HI = 4'h2, CC_LS = 4'h3,
                         CC_CC = 4'h4, CC_CS = 4'h5, CC_NE = 4'h6, CC_EQ = 4'h7,
                         CC_VC = 4'h8, CC_VS = 4'h9, CC_PL = 4'hA, CC_MI = 4'hB,
                         CC_GE = 4'hC, CC_LT = 4'hD, CC_GT = 4'hE, CC_LE = 4'hF;
  localparam int OP_LSB = 13, TYPE_BIT = 12, CC_BIT = 11, DST_LSB = 8,
                 SRCA_LSB = 5, SRCB_LSB = 2, SH_LSB = 0, COND_LSB = 8;
  localparam logic [15:0] HALT_INSN = 16'hE0FF;
endpackage

// File: rtl/stump_cond_eval.sv
// stump_cond_eval: branch condition evaluation against registered {N,Z,V,C} flags
module stump_cond_eval (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);
  logic n, z, v, c, base;
  assign {n, z, v, c} = flags;
  // odd condition codes are the complement of the even code below them
  always_comb begin
    case (cond[3:1])
      3'd0: base = 1'b1;
      3'd1: base = ~c & ~z;
      3'd2: base = ~c;
      3'd3: base = ~z;
      3'd4: base = ~v;
      3'd5: base = ~n;
      3'd6: base = n ~^ v;
      3'd7: base = ~z & (n ~^ v);
    endcase
  end
  assign taken = base ^ cond[0];
endmodule

// File: rtl/stump_control.sv
// stump_control: multi-cycle INIT/FETCH/EXECUTE/MEMORY sequencer for the Stump datapath
// Optional STUMP_HALT_EN: branch-always-to-self (16'hE0FF) parks the core in HALT until reset.
module stump_control
  import stump_ctrl_pkg::*;
#(
  parameter logic RESET_PC_SEL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ir,
  input  logic [3:0]  flags,
  input  logic        mem_ready,
  output logic        ir_en,
  output logic        pc_inc,
  output logic        pc_clr,
  output logic        reg_write,
  output logic [2:0]  dest,
  output logic [2:0]  srcA,
  output logic [2:0]  srcB,
  output logic [1:0]  shift_op,
  output logic        opB_sel,
  output logic        imm8_sel,
  output logic [2:0]  alu_func,
  output logic        cc_en,
  output logic        wdata_sel,
  output logic        mem_req,
  output logic        mem_wen,
  output logic        addr_sel,
  output logic        halted
);
  logic [2:0] state, nxt;
  logic [2:0] op, f_dst, f_sa, f_sb;
  logic       imm, taken, halt_ins;
  assign op    = ir[OP_LSB +: 3];
  assign imm   = ir[TYPE_BIT];
  assign f_dst = ir[DST_LSB +: 3];
  assign f_sa  = ir[SRCA_LSB +: 3];
  assign f_sb  = ir[SRCB_LSB +: 3];
  stump_cond_eval u_cond (.cond(ir[COND_LSB +: 4]), .flags(flags), .taken(taken));
`ifdef STUMP_HALT_EN
  assign halt_ins = ir == HALT_INSN;
`else
  assign halt_ins = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= nxt;
  end
  always_comb begin
    nxt = state;
    {ir_en, pc_inc, pc_clr, reg_write, opB_sel, imm8_sel, cc_en, wdata_sel} = '0;
    {mem_req, mem_wen, addr_sel, halted} = '0;
    {dest, srcA, srcB, alu_func} = '0;
    shift_op = 2'd0;
    case (state)
      S_INIT: begin
        pc_clr = RESET_PC_SEL & rst_n;
        nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        ir_en = mem_ready;
        pc_inc = mem_ready;
        nxt = mem_ready ? S_EXEC : S_FETCH;
      end
      S_EXEC: begin
        if (op == OP_BCC) begin
          srcA = 3'd7;
          dest = 3'd7;
          opB_sel = 1'b1;
          imm8_sel = 1'b1;
          reg_write = taken & ~halt_ins;
          nxt = halt_ins ? S_HALT : S_FETCH;
        end else if (op == OP_MEM) begin
          srcA = f_sa;
          srcB = imm ? 3'd0 : f_sb;
          opB_sel = imm;
          nxt = S_MEM;
        end else begin
          alu_func = op;
          srcA = f_sa;
          srcB = f_sb;
          dest = f_dst;
          reg_write = 1'b1;
          cc_en = ir[CC_BIT];
          opB_sel = imm;
          shift_op = imm ? 2'd0 : ir[SH_LSB +: 2];
          nxt = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        addr_sel = 1'b1;
        mem_wen = ir[CC_BIT];
        srcA = ir[CC_BIT] ? f_dst : 3'd0;
        reg_write = ~ir[CC_BIT] & mem_ready;
        wdata_sel = ~ir[CC_BIT] & mem_ready;
        dest = (~ir[CC_BIT] & mem_ready) ? f_dst : 3'd0;
        nxt = mem_ready ? S_FETCH : S_MEM;
      end
`ifdef STUMP_HALT_EN
      S_HALT: halted = 1'b1;
`endif
      default: nxt = S_INIT;
    endcase
  end
endmodule
